// File: rtl/pc_csr_unit_if.sv
// Datapath-side bundle of the program-counter / CSR-read unit.
// Combinational outputs are is_rd, is_inst. pc and misalign_* are registered.
// No backpressure: the unit accepts whatever the decoder presents every cycle.
interface pc_csr_unit_if;
   logic        enable_pc;
   logic [31:0] imm;
   logic [31:0] rs1;
   logic [11:0] opcode;
   logic        branch;
   logic        irr;
   logic [31:0] irr_dest;
   logic [31:0] irr_ret;
   logic [2:0]  cnt_inhibit;
   logic [31:0] pc;
   logic        is_rd;
   logic        is_inst;
   logic        misalign_trap;
   logic [31:0] misalign_addr;

   // Decoder / core side drives the instruction context.
   modport master (
      output enable_pc, imm, rs1, opcode, branch, irr, irr_dest, irr_ret, cnt_inhibit,
      input  pc, is_rd, is_inst, misalign_trap, misalign_addr
   );

   // The pc_csr_unit consumes the context and reports pc and ownership.
   modport slave (
      input  enable_pc, imm, rs1, opcode, branch, irr, irr_dest, irr_ret, cnt_inhibit,
      output pc, is_rd, is_inst, misalign_trap, misalign_addr
   );
endinterface

// File: rtl/pc_csr_unit.sv
// Program counter, next-PC selection, rd for JAL/JALR/AUIPC/LUI/CSRR and cycle/time/instret counters.
// Latency: rd/is_rd/is_inst combinational; pc, counters and misalign trap update on the next clk edge.
// No backpressure; optional misaligned-target trapping enabled by macro PC_MISALIGN_TRAP_EN.
module pc_csr_unit #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter int          CNT_W        = 64,
   parameter int          TIME_DIV     = 101
) (
   input  logic         clk,
   input  logic         rst,
   pc_csr_unit_if.slave bus,
   output logic [31:0]  rd
);

   localparam logic [11:0] OP_JAL    = 12'h06F;
   localparam logic [11:0] OP_JALR   = 12'h067;
   localparam logic [11:0] OP_AUIPC  = 12'h017;
   localparam logic [11:0] OP_LUI    = 12'h037;
   localparam logic [11:0] OP_CSRR   = 12'h073;
   localparam logic [11:0] OP_RETIRQ = 12'h398;
   localparam logic [6:0]  OP_BRANCH = 7'h63;

   localparam logic [11:0] CSR_CYCLE    = 12'hC00;
   localparam logic [11:0] CSR_TIME     = 12'hC01;
   localparam logic [11:0] CSR_INSTRET  = 12'hC02;
   localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
   localparam logic [11:0] CSR_TIMEH    = 12'hC81;
   localparam logic [11:0] CSR_INSTRETH = 12'hC82;

   localparam int          PW        = $clog2(TIME_DIV);
   localparam logic [PW-1:0] PRESC_TOP = PW'(TIME_DIV - 1);

   logic [31:0]    pc_q;
   logic [31:0]    pc_plus4;
   logic [31:0]    pc_plus_imm;
   logic [31:0]    jalr_target;
   logic [31:0]    pc_next;
   logic           misalign;
   logic           commit;

   logic [CNT_W-1:0] cycle_cnt;
   logic [CNT_W-1:0] time_cnt;
   logic [CNT_W-1:0] instret_cnt;
   logic [PW-1:0]    presc;

   logic [63:0]    cycle_ext;
   logic [63:0]    time_ext;
   logic [63:0]    instret_ext;
   logic [31:0]    csr_val;
   logic [31:0]    rd_val;
   logic           owns;

   assign pc_plus4    = pc_q + 32'd4;
   assign pc_plus_imm = pc_q + bus.imm;
   assign jalr_target = (bus.rs1 + bus.imm) & ~32'd1;

   // Next-PC selection; an interrupt request outranks any control transfer.
   always_comb begin
      pc_next = pc_plus4;
      if (bus.irr)
         pc_next = bus.irr_dest;
      else if (bus.opcode[6:0] == OP_BRANCH)
         pc_next = bus.branch ? pc_plus_imm : pc_plus4;
      else if (bus.opcode == OP_JALR)
         pc_next = jalr_target;
      else if (bus.opcode == OP_JAL)
         pc_next = pc_plus_imm;
      else if (bus.opcode == OP_RETIRQ)
         pc_next = bus.irr_ret;
   end

`ifdef PC_MISALIGN_TRAP_EN
   // A word-misaligned target is refused: pc and instret stay put.
   assign misalign = bus.enable_pc && (pc_next[1:0] != 2'b00);
`else
   assign misalign = 1'b0;
`endif

   assign commit = bus.enable_pc && !misalign;

   // Program counter register.
   always_ff @(posedge clk) begin
      if (!rst)
         pc_q <= RESET_VECTOR;
      else if (commit)
         pc_q <= pc_next;
   end

   assign bus.pc = pc_q;

`ifdef PC_MISALIGN_TRAP_EN
   logic        trap_q;
   logic [31:0] trap_addr_q;

   // One-cycle trap pulse; the rejected address is kept until the next trap.
   always_ff @(posedge clk) begin
      if (!rst) begin
         trap_q      <= 1'b0;
         trap_addr_q <= 32'd0;
      end else begin
         trap_q <= misalign;
         if (misalign)
            trap_addr_q <= pc_next;
      end
   end

   assign bus.misalign_trap = trap_q;
   assign bus.misalign_addr = trap_addr_q;
`else
   assign bus.misalign_trap = 1'b0;
   assign bus.misalign_addr = 32'd0;
`endif

   // Free-running cycle counter, frozen by cnt_inhibit[0].
   always_ff @(posedge clk) begin
      if (!rst)
         cycle_cnt <= '0;
      else if (!bus.cnt_inhibit[0])
         cycle_cnt <= cycle_cnt + 1'b1;
   end

   // Time prescaler and counter; inhibit freezes both so the phase is kept.
   always_ff @(posedge clk) begin
      if (!rst) begin
         presc    <= '0;
         time_cnt <= '0;
      end else if (!bus.cnt_inhibit[1]) begin
         if (presc == PRESC_TOP) begin
            presc    <= '0;
            time_cnt <= time_cnt + 1'b1;
         end else begin
            presc <= presc + 1'b1;
         end
      end
   end

   // Retired-instruction counter; counts only committed PC updates.
   always_ff @(posedge clk) begin
      if (!rst)
         instret_cnt <= '0;
      else if (commit && !bus.cnt_inhibit[2])
         instret_cnt <= instret_cnt + 1'b1;
   end

   assign cycle_ext   = 64'(cycle_cnt);
   assign time_ext    = 64'(time_cnt);
   assign instret_ext = 64'(instret_cnt);

   // CSR read mux; reads the pre-edge counter values, unknown addresses give 0.
   always_comb begin
      csr_val = 32'd0;
      case (bus.imm[11:0])
         CSR_CYCLE:    csr_val = cycle_ext[31:0];
         CSR_CYCLEH:   csr_val = cycle_ext[63:32];
         CSR_TIME:     csr_val = time_ext[31:0];
         CSR_TIMEH:    csr_val = time_ext[63:32];
         CSR_INSTRET:  csr_val = instret_ext[31:0];
         CSR_INSTRETH: csr_val = instret_ext[63:32];
         default:      csr_val = 32'd0;
      endcase
   end

   // Result select and ownership decode for the opcodes this unit writes back.
   always_comb begin
      rd_val = 32'd0;
      owns   = 1'b1;
      case (bus.opcode)
         OP_JAL,
         OP_JALR:  rd_val = pc_plus4;
         OP_AUIPC: rd_val = pc_plus_imm;
         OP_LUI:   rd_val = bus.imm;
         OP_CSRR:  rd_val = csr_val;
         default: begin
            rd_val = 32'd0;
            owns   = 1'b0;
         end
      endcase
   end

   assign bus.is_rd   = owns;
   assign bus.is_inst = owns;
   assign rd          = owns ? rd_val : 32'hzzzz_zzzz;

endmodule

// File: doc/pc_csr_unit.md
# pc_csr_unit

Parametrised program-counter and counter/CSR-read unit for the mriscvcore datapath. It computes the next PC for sequential flow, branches, JAL/JALR, interrupt entry and RETIRQ. It supplies rd for CSRR*, JAL/JALR, AUIPC and LUI, and maintains the cycle, time and instret counters. Compared with the previous generation it adds:
- configurable counter width, time prescaler and reset vector;
- per-counter inhibit;
- optional misaligned-target trapping.

## Interface
Parameters:
- RESET_VECTOR, 32'h0000_0000: PC value loaded on reset.
- CNT_W, 64: width of each counter, 33..64.
- TIME_DIV, 101: clk cycles per time increment, ≥ 2.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous and active-low.
- enable_pc  in  1  commits PC_next into pc and counts one retired instruction.
- imm  in  32  decoded immediate; also the CSR address for CSRR*.
- rs1  in  32  rs1 value, used by JALR.
- opcode  in  12  {funct3, 2'b0, opcode[6:0]}-style decode word from the decoder.
- branch  in  1  branch condition taken.
- irr  in  1  interrupt entry request.
- irr_dest  in  32  interrupt handler address.
- irr_ret  in  32  return address for RETIRQ.
- cnt_inhibit  in  3  per-counter freeze: [0] cycle, [1] time, [2] instret.
- rd  out  32  result value; 32'hzzzz_zzzz when is_rd=0.
- pc  out  32  current PC, registered.
- is_rd  out  1  this unit drives rd (combinational).
- is_inst  out  1  opcode is owned by this unit (combinational).
- misalign_trap  out  1  one-cycle pulse: a misaligned target was rejected.
- misalign_addr  out  32  the rejected target address.

## Operation
- Counters:
  - cycle increments every clk.
  - time increments when the prescaler reaches TIME_DIV-1. The prescaler then wraps to 0, giving a period of exactly TIME_DIV.
  - instret increments on enable_pc.
  - All counters wrap modulo 2^CNT_W.
  - Setting cnt_inhibit[i] freezes counter i. For time, the prescaler also holds its value.
- CSR read, when opcode=12'h073. Address is imm[11:0]; the result is zero-extended:
  - 0xC00 returns cycle[31:0]; 0xC80 returns cycle[CNT_W-1:32].
  - 0xC01 returns time[31:0]; 0xC81 returns time[CNT_W-1:32].
  - 0xC02 returns instret[31:0]; 0xC82 returns instret[CNT_W-1:32].
  - Any other address reads 0.
- rd and is_rd/is_inst per opcode:
  - 12'h06F JAL and 12'h067 JALR: rd = pc+4.
  - 12'h017 AUIPC: rd = pc+imm.
  - 12'h037 LUI: rd = imm.
  - 12'h073 CSRR*: rd = CSR value.
  - All of these set is_rd=1 and is_inst=1.
  - Any other opcode: is_rd=0, is_inst=0, rd high-Z.
- PC_next priority, highest first:
  1. irr: irr_dest.
  2. opcode[6:0]=7'h63: pc+imm if branch, else pc+4.
  3. JALR: (rs1+imm) & ~1.
  4. JAL: pc+imm.
  5. 12'h398 RETIRQ: irr_ret.
  6. Otherwise: pc+4.
- All address arithmetic is 32-bit modulo 2^32, with no overflow flag.

## Timing
- Reset (rst=0 at a clk edge):
  - pc = RESET_VECTOR.
  - All counters and the prescaler clear to 0.
  - misalign_trap = 0, misalign_addr = 0.
  - Reset overrides enable_pc and irr in the same cycle.
- pc updates on the clk edge where enable_pc=1; the new value is visible the next cycle.
- rd, is_rd, is_inst and the CSR mux are combinational from the current inputs and state, with zero latency.
- A CSR read returns the counter value before the current edge. An instret read in the same cycle as enable_pc returns the value before the increment.
- irr together with a branch or jump: irr wins. irr has no effect unless enable_pc=1.

## Configuration
- Macro PC_MISALIGN_TRAP_EN.
- Defined:
  - If enable_pc=1 and PC_next[1:0]≠0, pc holds its value and instret does not increment.
  - misalign_trap=1 for exactly one cycle, registered. misalign_addr latches PC_next and holds it until the next trap or reset.
- Undefined:
  - PC_next is loaded unchanged.
  - misalign_trap and misalign_addr are tied to 0.

## Test plan
- Reset with RESET_VECTOR=32'h100, then 3 cycles with enable_pc=1 and opcode=12'h013: pc goes 0x100 → 0x104 → 0x108 → 0x10C; instret=3; a CSR read at 0xC02 gives 3.
- TIME_DIV=4, run 12 cycles after reset: CSR 0xC01 reads 3. Set cnt_inhibit=3'b010 for 8 more cycles: still reads 3, while CSR 0xC00 advanced by 8.
- CNT_W=40 with cycle forced to 40'hFF_FFFF_FFFF: one clk later cycle reads 0; CSR 0xC80 reads 0 (previous cycle: 32'h0000_00FF).
- pc=0x200, branch opcode, imm=-8, branch=1: pc becomes 0x1F8. Same with irr=1, irr_dest=0x80: pc becomes 0x80.
- pc=0x40, JALR with rs1=0x1001, imm=2: pc becomes 0x1002 and rd=0x44.
- With PC_MISALIGN_TRAP_EN defined, pc=0x10, JAL with imm=6: pc stays 0x10, misalign_trap pulses for 1 cycle, misalign_addr=0x16, instret unchanged. With the macro undefined, the same stimulus gives pc=0x16 and no trap.
